// File: rtl/alu4_seq.sv
// Sequential 4-bit ALU: accept a command in IDLE, compute in EXEC, hold the result in DONE.
// Optional macro ALU4_SAT_EN saturates signed add/sub overflow instead of wrapping.
module alu4_seq (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [3:0]   a,
  input  logic [3:0]   b,
  input  logic         use_acc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   result,
  output logic         c,
  output logic         n,
  output logic         z,
  output logic         v,
  output logic [3:0]   acc
);

  localparam int unsigned DW  = 4;
  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_NOTA = 3'b000;
  localparam logic [OPW-1:0] OP_NOTB = 3'b001;
  localparam logic [OPW-1:0] OP_AND  = 3'b010;
  localparam logic [OPW-1:0] OP_OR   = 3'b011;
  localparam logic [OPW-1:0] OP_XOR  = 3'b100;
  localparam logic [OPW-1:0] OP_XNOR = 3'b101;
  localparam logic [OPW-1:0] OP_ADD  = 3'b110;
  localparam logic [OPW-1:0] OP_SUB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   result_q, result_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic            c_q, c_d;
  logic            n_q, n_d;
  logic            z_q, z_d;
  logic            v_q, v_d;

  logic [DW-1:0]   b_eff;
  logic            cin;
  logic [DW:0]     sum;
  logic            ovf;
  logic            is_arith;
  logic [DW-1:0]   alu_r;
  logic [DW-1:0]   res_fin;
  logic            alu_c;
  logic            alu_v;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the upcoming state
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_d)
      IDLE:    in_ready_d  = 1'b1;
      DONE:    out_valid_d = 1'b1;
      default: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Shared adder: subtraction is A + ~B + 1
  always_comb begin
    cin      = (op_q == OP_SUB);
    b_eff    = cin ? ~b_q : b_q;
    sum      = {1'b0, a_q} + {1'b0, b_eff} + (DW+1)'(cin);
    ovf      = (a_q[DW-1] == b_eff[DW-1]) && (sum[DW-1] != a_q[DW-1]);
    is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
  end

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op_q)
      OP_NOTA: alu_r = ~a_q;
      OP_NOTB: alu_r = ~b_q;
      OP_AND:  alu_r = a_q & b_q;
      OP_OR:   alu_r = a_q | b_q;
      OP_XOR:  alu_r = a_q ^ b_q;
      OP_XNOR: alu_r = ~(a_q ^ b_q);
      OP_ADD, OP_SUB: begin
        alu_r = sum[DW-1:0];
        alu_c = sum[DW];
        alu_v = ovf;
      end
      default: alu_r = '0;
    endcase
  end

`ifdef ALU4_SAT_EN
  // Saturate toward the sign of the operands that overflowed
  always_comb begin
    res_fin = alu_r;
    if (is_arith && ovf) begin
      res_fin = a_q[DW-1] ? 4'b1000 : 4'b0111;
    end
  end
`else
  always_comb begin
    res_fin = alu_r;
    if (is_arith && 1'b0) begin
      res_fin = '0;
    end
  end
`endif

  // Operand capture on acceptance, result/flag capture on EXEC
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    acc_d    = acc_q;
    c_d      = c_q;
    n_d      = n_q;
    z_d      = z_q;
    v_d      = v_q;
    if (state_q == IDLE && in_valid) begin
      op_d = op;
      a_d  = use_acc ? acc_q : a;
      b_d  = b;
    end
    if (state_q == EXEC) begin
      result_d = res_fin;
      acc_d    = res_fin;
      c_d      = alu_c;
      n_d      = alu_r[DW-1];
      z_d      = (res_fin == '0);
      v_d      = alu_v;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      acc_q       <= '0;
      c_q         <= 1'b0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      acc_q       <= acc_d;
      c_q         <= c_d;
      n_q         <= n_d;
      z_q         <= z_d;
      v_q         <= v_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign acc       = acc_q;
  assign c         = c_q;
  assign n         = n_q;
  assign z         = z_q;
  assign v         = v_q;

endmodule

// File: tb/tb_alu4_seq.sv
// Scoreboard bench for alu4_seq: driver pushes model expectations, monitor pops on each output handshake.
// Define ALU4_SAT_EN for both RTL and bench to check the saturating build.
module tb_alu4_seq;

  typedef struct packed {
    logic [3:0] r;
    logic       c;
    logic       n;
    logic       z;
    logic       v;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       use_acc;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic       c, n, z, v;
  logic [3:0] acc;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  int   model_acc = 0;
  logic hold_ready = 1'b0;

  alu4_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .use_acc(use_acc), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .c(c), .n(n), .z(z), .v(v), .acc(acc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Reference model from the operation table with signed/unsigned integer arithmetic
  function automatic exp_t model(input logic [2:0] op_i, input int av, input int bv);
    exp_t e;
    int   sa, sb, s, wr, fin;
    e  = '0;
    sa = (av >= 8) ? av - 16 : av;
    sb = (bv >= 8) ? bv - 16 : bv;
    s  = 0;
    wr = 0;
    case (op_i)
      3'd0: wr = 15 - av;
      3'd1: wr = 15 - bv;
      3'd2: wr = av & bv;
      3'd3: wr = av | bv;
      3'd4: wr = av ^ bv;
      3'd5: wr = 15 - (av ^ bv);
      3'd6: begin wr = (av + bv) % 16;      e.c = ((av + bv) > 15); s = sa + sb; end
      default: begin wr = (av - bv + 16) % 16; e.c = (av >= bv);   s = sa - sb; end
    endcase
    if (op_i >= 3'd6) e.v = (s > 7) || (s < -8);
    e.n = (wr >= 8);
    fin = wr;
`ifdef ALU4_SAT_EN
    if (e.v) fin = (s > 7) ? 7 : 8;
`endif
    e.r = 4'(fin);
    e.z = (fin == 0);
    return e;
  endfunction

  // Consumer back-pressure: random unless held low
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare on handshake, check stability while stalled
  logic       prev_stall = 1'b0;
  logic [7:0] prev_out;
  initial prev_out = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_stable", 32'({result, c, n, z, v}), 32'(prev_out));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result_flags_acc", 32'({result, c, n, z, v, acc}), 32'({e.r, e.c, e.n, e.z, e.v, e.r}));
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_out   <= {result, c, n, z, v};
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic issue(input logic [2:0] o, input logic [3:0] ai, input logic [3:0] bi, input logic ua);
    int   cnt;
    int   av;
    exp_t e;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    op = o; a = ai; b = bi; use_acc = ua; in_valid = 1'b1;
    av = ua ? model_acc : int'(ai);
    e  = model(o, av, int'(bi));
    sb_q.push_back(e);
    model_acc = int'(e.r);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = 4'($urandom); b = 4'($urandom); use_acc = 1'($urandom);
    chk("accept_in_ready", 32'(in_ready), 32'd0);
    chk("accept_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic wait_out();
    @(posedge clk); #1;
    chk("latency_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic directed(input string nm, input logic [2:0] o, input logic [3:0] ai,
                          input logic [3:0] bi, input logic ua, input logic [3:0] req_r);
    issue(o, ai, bi, ua);
    wait_out();
    chk(nm, 32'(result), 32'(req_r));
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("wait_idle", 32'(in_ready), 32'd1);
  endtask

  task automatic do_reset_check(input string nm);
    reset = 1'b1;
    #1;
    chk(nm, 32'({in_ready, out_valid, result, c, n, z, v, acc}), 32'({1'b1, 1'b0, 4'h0, 4'h0, 4'h0}));
    sb_q.delete();
    model_acc = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] hold_r;
    reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; use_acc = 1'b0;
    @(posedge clk); #1;
    chk("reset_state", 32'({in_ready, out_valid, result, c, n, z, v, acc}), 32'({1'b1, 1'b0, 4'h0, 4'h0, 4'h0}));
    reset = 1'b0;

    directed("add_basic", 3'b110, 4'b0100, 4'b0011, 1'b0, 4'b0111);
`ifdef ALU4_SAT_EN
    directed("add_ovf", 3'b110, 4'b1000, 4'b1000, 1'b0, 4'b1000);
    directed("sub_ovf", 3'b111, 4'b1010, 4'b0101, 1'b0, 4'b1000);
`else
    directed("add_ovf", 3'b110, 4'b1000, 4'b1000, 1'b0, 4'b0000);
    directed("sub_ovf", 3'b111, 4'b1010, 4'b0101, 1'b0, 4'b0101);
`endif
    directed("sub_borrow", 3'b111, 4'b0101, 4'b0111, 1'b0, 4'b1110);
    directed("xor",  3'b100, 4'b0011, 4'b0101, 1'b0, 4'b0110);
    directed("xnor", 3'b101, 4'b0011, 4'b0101, 1'b0, 4'b1001);
    directed("and",  3'b010, 4'b0011, 4'b0101, 1'b0, 4'b0001);
    directed("or",   3'b011, 4'b0011, 4'b0101, 1'b0, 4'b0111);
    directed("nota", 3'b000, 4'b0011, 4'b0101, 1'b0, 4'b1100);
    directed("notb", 3'b001, 4'b0011, 4'b0101, 1'b0, 4'b1010);

    // Accumulate, then stall the consumer and poke in_valid
    directed("acc_seed", 3'b110, 4'b0001, 4'b0001, 1'b0, 4'b0010);
    chk("acc_value", 32'(acc), 32'd2);
    wait_idle();
    hold_ready = 1'b1;
    directed("acc_use", 3'b110, 4'b1111, 4'b0011, 1'b1, 4'b0101);
    hold_r = result;
    repeat (5) begin
      in_valid = 1'b1; op = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_result", 32'(result), 32'(hold_r));
    end
    in_valid = 1'b0;
    hold_ready = 1'b0;

    // Randomized traffic, including back-to-back accumulator reads
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 2) == 0));
      wait_out();
    end

    // Reset during EXEC discards the command
    wait_idle();
    issue(3'b110, 4'b0011, 4'b0100, 1'b0);
    do_reset_check("reset_in_exec");
    chk("ready_after_reset", 32'(in_ready), 32'd1);
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_valid_after_reset", 32'(out_valid), 32'd0);
    end

    // Reset during DONE, then accept on the first edge after release
    issue(3'b111, 4'b0001, 4'b0010, 1'b0);
    wait_out();
    do_reset_check("reset_in_done");
    issue(3'b110, 4'b0010, 4'b0010, 1'b1);
    wait_out();
    chk("post_reset_acc_op", 32'(result), 32'd2);

    begin
      int cnt;
      cnt = 0;
      while (sb_q.size() != 0 && cnt < 50) begin
        @(posedge clk); #1;
        cnt++;
      end
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
